hazard_scoreboard: RTL and testbench

Parametrised scoreboard-based hazard unit for the MIPS pipeline decode stage. It replaces purely comparator-based stall detection with one countdown timer per architectural register. The timers give result-ready tracking for operations of different latency (ALU, load, multi-cycle multiply), and the unit also detects WAW ordering hazards and structural hazards on a non-pipelined multiply unit. It sits beside the ID stage, drives the pipeline stall and issue signals, and keeps a stall-cycle statistics counter.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/sb_countdown.sv | 36 +++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard:
// op-class encodings, stall-cause bit positions, latency select.
package hazard_pkg;

    typedef enum logic [1:0] {
        OP_ALU  = 2'b00,
        OP_LOAD = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_class_e;

    localparam int CAUSE_RAW    = 0;
    localparam int CAUSE_WAW    = 1;
    localparam int CAUSE_STRUCT = 2;

    // Reserved class falls back to ALU latency.
    function automatic int unsigned lat_sel(
        input op_class_e   op,
        input int unsigned alu,
        input int unsigned ld,
        input int unsigned mul
    );
        case (op)
            OP_MUL:  return mul;
            OP_LOAD: return ld;
            default: return alu;
        endcase
    endfunction

endpackage

// File: rtl/sb_countdown.sv
// Saturating down-counter with synchronous load and reset.
// Ports: i_clk, i_rst_n, i_load, i_load_val -> o_cnt.
module sb_countdown #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over the decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: RAW/WAW/structural stall
// decision for ID, issue strobe and saturating stall counter.
// Ports: i_clk, i_rst_n, ID operand/dest/class inputs, i_flush,
// i_stat_clr -> o_stall, o_issue, o_stall_cause, o_stall_cycles.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 3,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int EX_SLACK = 1,
    parameter int ID_SLACK = 0,
    parameter int STAT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_valid,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic              i_rs_used,
    input  logic              i_rt_used,
    input  logic              i_rs_use_id,
    input  logic              i_rt_use_id,
    input  logic [REG_W-1:0]  i_rd,
    input  logic              i_rd_write,
    input  logic [1:0]        i_op_class,
    input  logic              i_flush,
    input  logic              i_stat_clr,
    output logic              o_stall,
    output logic              o_issue,
    output logic [2:0]        o_stall_cause,
    output logic [STAT_W-1:0] o_stall_cycles
);

    import hazard_pkg::*;

    localparam int LAT_MAX = (2 ** CNT_W) - 1;

    if (ALU_LAT < 1 || ALU_LAT > LAT_MAX) begin : g_bad_alu
        $error("ALU_LAT out of range for CNT_W");
    end
    if (LOAD_LAT < 1 || LOAD_LAT > LAT_MAX) begin : g_bad_load
        $error("LOAD_LAT out of range for CNT_W");
    end
    if (MUL_LAT < 1 || MUL_LAT > LAT_MAX) begin : g_bad_mul
        $error("MUL_LAT out of range for CNT_W");
    end
    if (REG_W != $clog2(NREG)) begin : g_bad_regw
        $error("REG_W must equal clog2(NREG)");
    end

    localparam logic [CNT_W-1:0] EX_SL   = CNT_W'(EX_SLACK);
    localparam logic [CNT_W-1:0] ID_SL   = CNT_W'(ID_SLACK);
    localparam logic [CNT_W-1:0] MUL_OCC = CNT_W'(MUL_LAT - 1);

    op_class_e        op;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] tmr_q [NREG];
    logic [CNT_W-1:0] mul_busy_q;
    logic [STAT_W-1:0] stat_q;
    logic [STAT_W-1:0] stat_d;

    logic [CNT_W-1:0] rs_lim;
    logic [CNT_W-1:0] rt_lim;
    logic raw_rs;
    logic raw_rt;
    logic raw;
    logic waw;
    logic strh;
    logic hazard;
    logic go;
    logic rd_load;

    assign op  = op_class_e'(i_op_class);
    assign lat = CNT_W'(lat_sel(op, ALU_LAT, LOAD_LAT, MUL_LAT));

    assign rs_lim = i_rs_use_id ? ID_SL : EX_SL;
    assign rt_lim = i_rt_use_id ? ID_SL : EX_SL;

    assign raw_rs = i_rs_used && (i_rs != '0) && (tmr_q[i_rs] > rs_lim);
    assign raw_rt = i_rt_used && (i_rt != '0) && (tmr_q[i_rt] > rt_lim);
    assign raw    = raw_rs | raw_rt;

    // Equal remaining time is fine: the new write lands no earlier.
    assign waw  = i_rd_write && (i_rd != '0) && (tmr_q[i_rd] > lat);
    assign strh = (op == OP_MUL) && (mul_busy_q != '0);

    assign hazard = raw | waw | strh;

    // Reset forces the decision outputs low.
    assign go      = i_rst_n & i_id_valid & ~i_flush;
    assign o_stall = go & hazard;
    assign o_issue = go & ~hazard;

    always_comb begin
        o_stall_cause               = '0;
        o_stall_cause[CAUSE_RAW]    = o_stall & raw;
        o_stall_cause[CAUSE_WAW]    = o_stall & waw;
        o_stall_cause[CAUSE_STRUCT] = o_stall & strh;
    end

    assign rd_load = o_issue & i_rd_write & (i_rd != '0);

    assign tmr_q[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_tmr
        sb_countdown #(
            .CNT_W(CNT_W)
        ) u_tmr (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_load     (rd_load && (i_rd == REG_W'(r))),
            .i_load_val (lat),
            .o_cnt      (tmr_q[r])
        );
    end

    sb_countdown #(
        .CNT_W(CNT_W)
    ) u_mul_busy (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (o_issue && (op == OP_MUL)),
        .i_load_val (MUL_OCC),
        .o_cnt      (mul_busy_q)
    );

    always_comb begin
        stat_d = stat_q;
        if (i_stat_clr) begin
            stat_d = '0;
        end else if (o_stall && (stat_q != '1)) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign o_stall_cycles = stat_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: timestamp reference model,
// directed scenarios with literal stall counts, random traffic.
module tb_hazard_scoreboard;

    localparam int A_LAT = 1;
    localparam int L_LAT = 2;
    localparam int M_LAT = 4;
    localparam int EXS   = 1;
    localparam int IDS   = 0;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        rs_used, rt_used, rs_id, rt_id, rd_write;
    logic [1:0]  op;
    logic        flush, clr;
    logic        o_stall, o_issue;
    logic [2:0]  o_cause;
    logic [15:0] o_stat;

    int tests;
    int fails;

    // Model: cycle at which each register's result is ready
    // (timer reads 0), cycle at which the multiplier is free.
    int avail [32];
    int mul_free;
    int cyc;
    int mstat;
    logic e_stall, e_issue;

    hazard_scoreboard dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_valid     (valid),
        .i_rs           (rs),
        .i_rt           (rt),
        .i_rs_used      (rs_used),
        .i_rt_used      (rt_used),
        .i_rs_use_id    (rs_id),
        .i_rt_use_id    (rt_id),
        .i_rd           (rd),
        .i_rd_write     (rd_write),
        .i_op_class     (op),
        .i_flush        (flush),
        .i_stat_clr     (clr),
        .o_stall        (o_stall),
        .o_issue        (o_issue),
        .o_stall_cause  (o_cause),
        .o_stall_cycles (o_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o);
        if (o == 2'd2) return M_LAT;
        if (o == 2'd1) return L_LAT;
        return A_LAT;
    endfunction

    always @(negedge clk) begin
        int  lat;
        bit  r1, r2, w, s, hz, g;
        lat = lat_of(op);
        r1 = rs_used && rs != 0 &&
             (avail[rs] - cyc) > (rs_id ? IDS : EXS);
        r2 = rt_used && rt != 0 &&
             (avail[rt] - cyc) > (rt_id ? IDS : EXS);
        w  = rd_write && rd != 0 && (avail[rd] - cyc) > lat;
        s  = (op == 2'd2) && (mul_free > cyc);
        hz = r1 | r2 | w | s;
        g  = rst_n && valid && !flush;
        e_stall <= g && hz;
        e_issue <= g && !hz;
        chk("stall", int'(o_stall), int'(g && hz));
        chk("issue", int'(o_issue), int'(g && !hz));
        chk("cause", int'(o_cause),
            (g && hz) ? int'({s, w, r1 | r2}) : 0);
        chk("stat", int'(o_stat), mstat);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) avail[r] <= 0;
            mul_free <= 0;
            mstat    <= 0;
        end else begin
            if (e_issue && rd_write && rd != 0)
                avail[rd] <= cyc + lat_of(op) + 1;
            if (e_issue && op == 2'd2)
                mul_free <= cyc + M_LAT;
            if (clr)
                mstat <= 0;
            else if (e_stall && mstat < 65535)
                mstat <= mstat + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until it issues.
    task automatic instr(
        input logic [1:0] o,
        input int s, input bit su, input bit sid,
        input int t, input bit tu, input bit tid,
        input int d, input bit dw,
        output int stalls, output int cause
    );
        bit done;
        op = o;
        rs = 5'(s); rs_used = su; rs_id = sid;
        rt = 5'(t); rt_used = tu; rt_id = tid;
        rd = 5'(d); rd_write = dw;
        valid = 1'b1;
        stalls = 0;
        cause = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (o_issue) done = 1;
            else begin
                if (stalls == 0) cause = int'(o_cause);
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        chk("issued_within_bound", int'(done), 1);
        valid = 1'b0;
    endtask

    int st, ca;

    initial begin
        tests = 0; fails = 0; cyc = 0; mstat = 0; mul_free = 0;
        for (int r = 0; r < 32; r++) avail[r] = 0;
        e_stall = 0; e_issue = 0;
        rst_n = 1'b0; valid = 1'b1; op = 2'd2;
        rs = 5'd1; rt = 5'd2; rd = 5'd3;
        rs_used = 1; rt_used = 1; rs_id = 0; rt_id = 0;
        rd_write = 1; flush = 0; clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_forced", int'(o_issue), 0);
        chk("rst_stat", int'(o_stat), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid = 1'b0;
        idle(1);

        instr(2'd0, 0, 0, 0, 0, 0, 0, 5, 1, st, ca);
        chk("alu_issue", st, 0);
        instr(2'd0, 5, 1, 0, 0, 0, 0, 10, 1, st, ca);
        chk("alu_ex_use", st, 0);

        instr(2'd1, 0, 0, 0, 0, 0, 0, 8, 1, st, ca);
        instr(2'd0, 0, 0, 0, 8, 1, 0, 11, 1, st, ca);
        chk("load_use_stalls", st, 1);
        chk("load_use_cause", ca, 1);
        chk("load_use_stat", int'(o_stat), 1);

        instr(2'd2, 0, 0, 0, 0, 0, 0, 3, 1, st, ca);
        instr(2'd0, 3, 1, 1, 0, 0, 0, 0, 0, st, ca);
        chk("mul_branch_stalls", st, 4);

        idle(5);
        instr(2'd2, 0, 0, 0, 0, 0, 0, 4, 1, st, ca);
        instr(2'd2, 0, 0, 0, 0, 0, 0, 6, 1, st, ca);
        chk("mul_mul_stalls", st, 3);
        chk("mul_mul_cause", ca, 4);
        idle(5);
        instr(2'd2, 0, 0, 0, 0, 0, 0, 2, 1, st, ca);
        instr(2'd1, 0, 0, 0, 0, 0, 0, 2, 1, st, ca);
        chk("waw_stalls", st, 2);
        chk("waw_cause", ca, 2);
        chk("stat_total", int'(o_stat), 10);

        idle(5);
        instr(2'd1, 0, 0, 0, 0, 0, 0, 0, 1, st, ca);
        chk("load_r0", st, 0);
        instr(2'd0, 0, 1, 1, 0, 1, 1, 12, 1, st, ca);
        chk("use_r0", st, 0);
        instr(2'd1, 7, 1, 0, 0, 0, 0, 7, 1, st, ca);
        chk("self_dep", st, 0);

        idle(5);
        instr(2'd2, 0, 0, 0, 0, 0, 0, 11, 1, st, ca);
        instr(2'd1, 0, 0, 0, 0, 0, 0, 9, 1, st, ca);
        op = 2'd0; rs = 5'd9; rs_used = 1; rs_id = 0;
        rt_used = 0; rd_write = 0; valid = 1; flush = 1;
        @(negedge clk);
        chk("flush_stall", int'(o_stall), 0);
        chk("flush_issue", int'(o_issue), 0);
        chk("flush_stat", int'(o_stat), 10);
        @(posedge clk); #1;
        flush = 0; valid = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        instr(2'd0, 9, 1, 1, 0, 0, 0, 0, 0, st, ca);
        chk("post_rst_r9", st, 0);
        instr(2'd0, 11, 1, 1, 0, 0, 0, 0, 0, st, ca);
        chk("post_rst_r11", st, 0);
        chk("post_rst_stat", int'(o_stat), 0);

        for (int k = 0; k < 3000; k++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            valid    = ($urandom_range(0, 3) != 0);
            op       = 2'($urandom_range(0, 3));
            rs       = 5'($urandom_range(0, 7));
            rt       = 5'($urandom_range(0, 7));
            rd       = 5'($urandom_range(0, 7));
            rs_used  = 1'($urandom_range(0, 1));
            rt_used  = 1'($urandom_range(0, 1));
            rs_id    = 1'($urandom_range(0, 1));
            rt_id    = 1'($urandom_range(0, 1));
            rd_write = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            clr      = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        valid = 0; flush = 0; clr = 0; rst_n = 1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
